// File: rtl/monitor_types.sv
// Shared types for the store-path trace monitor: monitor states, store sizes,
// the CPU memory-op encoding and the store decode helper.
package monitor_types;

  // Monitor life cycle: RUN until a completion write or the watchdog fires.
  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DONE    = 2'd1,
    TIMEOUT = 2'd2
  } mon_state_t;

  // Width of a captured store.
  typedef enum logic [1:0] {
    ST_B = 2'd0,
    ST_H = 2'd1,
    ST_W = 2'd2
  } st_size_t;

  // Access type driven by the CPU alongside the memory strobe.
  typedef enum logic [3:0] {
    MEM_NOP = 4'd0,
    MEM_LB  = 4'd1,
    MEM_LH  = 4'd2,
    MEM_LW  = 4'd3,
    MEM_LBU = 4'd4,
    MEM_LHU = 4'd5,
    MEM_SB  = 4'd6,
    MEM_SH  = 4'd7,
    MEM_SW  = 4'd8
  } mem_op_t;

  // Result of classifying one access: is it a store, and how wide.
  typedef struct packed {
    logic     valid;
    st_size_t size;
  } st_decode_t;

  localparam int unsigned CYCLE_W = 32;
  localparam int unsigned SIZE_W  = 2;
  localparam int unsigned DROP_W  = 16;

  // Map an access type onto store-valid plus size; loads and NOP are not stores.
  function automatic st_decode_t decode_store(input mem_op_t op);
    st_decode_t d;
    d.valid = 1'b0;
    d.size  = ST_W;
    case (op)
      MEM_SB: begin
        d.valid = 1'b1;
        d.size  = ST_B;
      end
      MEM_SH: begin
        d.valid = 1'b1;
        d.size  = ST_H;
      end
      MEM_SW: begin
        d.valid = 1'b1;
        d.size  = ST_W;
      end
      default: begin
        d.valid = 1'b0;
        d.size  = ST_W;
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Circular trace buffer. Overwrites the oldest entry when pushed while full
// (reporting the loss on o_drop), accepts push and pop in the same cycle, and
// presents the head entry from registers so the consumer sees a stable value.
module trace_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_head,
  output logic             o_drop
);

  localparam int unsigned   PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0] ONE_CNT  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] ONE_PTR = PTR_W'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W:0]   r_count;
  logic             r_valid;
  logic [WIDTH-1:0] r_head_data;

  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_drop;
  logic [PTR_W-1:0] w_wr_idx;
  logic [PTR_W-1:0] w_head_next;
  logic [PTR_W:0]   w_count_next;
  logic [WIDTH-1:0] w_head_data_next;

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == FULL_CNT);
  assign w_pop    = i_pop && !w_empty;
  assign w_drop   = i_push && w_full && !w_pop;
  // When full the low count bits wrap to zero, so the write lands on the head.
  assign w_wr_idx = r_head + r_count[PTR_W-1:0];

  // Next head pointer and occupancy from this cycle's push/pop/overwrite.
  always_comb begin
    w_head_next  = r_head;
    w_count_next = r_count;
    if (w_pop || w_drop) begin
      w_head_next = r_head + ONE_PTR;
    end else begin
      w_head_next = r_head;
    end
    if (i_push && !w_pop && !w_full) begin
      w_count_next = r_count + ONE_CNT;
    end else if (w_pop && !i_push) begin
      w_count_next = r_count - ONE_CNT;
    end else begin
      w_count_next = r_count;
    end
  end

  // Head payload for the next cycle; bypass the incoming entry when it lands at the new head.
  always_comb begin
    w_head_data_next = '0;
    if (w_count_next == '0) begin
      w_head_data_next = '0;
    end else if (i_push && (w_wr_idx == w_head_next)) begin
      w_head_data_next = i_data;
    end else begin
      w_head_data_next = r_mem[w_head_next];
    end
  end

  // Entry storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[w_wr_idx] <= i_data;
    end
  end

  // Pointers, occupancy and the registered head view.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_head      <= '0;
      r_count     <= '0;
      r_valid     <= 1'b0;
      r_head_data <= '0;
    end else begin
      r_head      <= w_head_next;
      r_count     <= w_count_next;
      r_valid     <= (w_count_next != '0);
      r_head_data <= w_head_data_next;
    end
  end

  assign o_valid = r_valid;
  assign o_head  = r_head_data;
  assign o_drop  = w_drop;

endmodule

// File: rtl/store_trace_monitor.sv
// Passive monitor on the CPU store path: records in-window stores with a cycle
// stamp, decodes the tohost completion write and runs a completion watchdog.
module store_trace_monitor
  import monitor_types::*;
#(
  parameter int unsigned       ADDR_W         = 32,
  parameter int unsigned       DATA_W         = 32,
  parameter int unsigned       DEPTH          = 16,
  parameter logic [ADDR_W-1:0] WIN_LO         = ADDR_W'(32'h0000_0000),
  parameter logic [ADDR_W-1:0] WIN_HI         = ADDR_W'(32'hFFFF_FFFF),
  parameter logic [ADDR_W-1:0] TOHOST_ADDR    = ADDR_W'(32'h0000_0FFC),
  parameter logic [31:0]       TIMEOUT_CYCLES = 32'd10000
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              mem_wr_en,
  input  mem_op_t           mem_op,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data_in,
  output logic              trace_valid,
  input  logic              trace_ready,
  output logic [31:0]       trace_cycle,
  output logic [ADDR_W-1:0] trace_addr,
  output logic [DATA_W-1:0] trace_data,
  output st_size_t          trace_size,
  output logic              overflow,
  output logic [15:0]       drop_count,
  output logic              done,
  output logic              pass,
  output logic [DATA_W-2:0] exit_code,
  output logic              timeout,
  output mon_state_t        state
);

  localparam int unsigned ENTRY_W = CYCLE_W + ADDR_W + DATA_W + SIZE_W;

  mon_state_t          r_state;
  mon_state_t          w_state_next;
  logic [CYCLE_W-1:0]  r_cycle;
  logic                r_done;
  logic                r_pass;
  logic [DATA_W-2:0]   r_exit_code;
  logic                r_timeout;
  logic                r_overflow;
  logic [DROP_W-1:0]   r_drop_count;

  st_decode_t          w_dec;
  logic                w_store;
  logic                w_is_tohost;
  logic                w_complete;
  logic                w_finish;
  logic                w_timeout_hit;
  logic [CYCLE_W-1:0]  w_cycle_inc;
  logic [ADDR_W:0]     w_lo_diff;
  logic [ADDR_W:0]     w_hi_diff;
  logic                w_in_win;
  logic                w_push;
  logic                w_pop;
  logic                w_drop;
  logic                w_head_valid;
  logic [ENTRY_W-1:0]  w_entry;
  logic [ENTRY_W-1:0]  w_head;

  assign w_dec       = decode_store(mem_op);
  assign w_store     = mem_wr_en && w_dec.valid;
  assign w_is_tohost = (mem_addr == TOHOST_ADDR);
  assign w_complete  = w_store && w_is_tohost && mem_data_in[0];
  assign w_finish    = (r_state == RUN) && w_complete;

  // Window bounds via borrow of a widened subtract: unsigned, inclusive, and
  // free of always-true compares when a bound sits at the end of the range.
  assign w_lo_diff = {1'b0, mem_addr} - {1'b0, WIN_LO};
  assign w_hi_diff = {1'b0, WIN_HI} - {1'b0, mem_addr};
  assign w_in_win  = !w_lo_diff[ADDR_W] && !w_hi_diff[ADDR_W];

  // Any store to tohost is a control write, never trace data.
  assign w_push  = (r_state == RUN) && w_store && w_in_win && !w_is_tohost;
  assign w_pop   = w_head_valid && trace_ready;
  assign w_entry = {r_cycle, mem_addr, mem_data_in, w_dec.size};

  // Saturating increment of the cycle stamp and the watchdog compare on its next value.
  always_comb begin
    w_cycle_inc   = r_cycle;
    w_timeout_hit = 1'b0;
    if (r_cycle == {CYCLE_W{1'b1}}) begin
      w_cycle_inc = r_cycle;
    end else begin
      w_cycle_inc = r_cycle + 32'd1;
    end
    if ((r_state == RUN) && (TIMEOUT_CYCLES != 32'd0) &&
        (w_cycle_inc == TIMEOUT_CYCLES) && !w_complete) begin
      w_timeout_hit = 1'b1;
    end else begin
      w_timeout_hit = 1'b0;
    end
  end

  // Next-state logic; completion takes priority over a same-cycle timeout.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      RUN: begin
        if (w_finish) begin
          w_state_next = DONE;
        end else if (w_timeout_hit) begin
          w_state_next = TIMEOUT;
        end else begin
          w_state_next = RUN;
        end
      end
      DONE:    w_state_next = DONE;
      TIMEOUT: w_state_next = TIMEOUT;
      default: w_state_next = RUN;
    endcase
  end

  // Monitor state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Cycle counter runs only in RUN and freezes once the run has ended.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cycle <= '0;
    end else if (r_state == RUN) begin
      r_cycle <= w_cycle_inc;
    end
  end

  // Completion decode and watchdog flag, captured on the deciding edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_exit_code <= '0;
      r_timeout   <= 1'b0;
    end else begin
      if (w_finish) begin
        r_done      <= 1'b1;
        r_pass      <= (mem_data_in[DATA_W-1:1] == '0);
        r_exit_code <= mem_data_in[DATA_W-1:1];
      end
      if (w_timeout_hit) begin
        r_timeout <= 1'b1;
      end
    end
  end

  // Sticky overflow and saturating count of overwritten trace entries.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_drop_count != 16'hFFFF) begin
        r_drop_count <= r_drop_count + 16'd1;
      end
    end
  end

  trace_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_trace_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .i_push  (w_push),
    .i_data  (w_entry),
    .i_pop   (w_pop),
    .o_valid (w_head_valid),
    .o_head  (w_head),
    .o_drop  (w_drop)
  );

  assign trace_valid = w_head_valid;
  assign trace_cycle = w_head[ENTRY_W-1 -: CYCLE_W];
  assign trace_addr  = w_head[ADDR_W+DATA_W+SIZE_W-1 -: ADDR_W];
  assign trace_data  = w_head[DATA_W+SIZE_W-1 -: DATA_W];
  assign trace_size  = st_size_t'(w_head[SIZE_W-1:0]);
  assign overflow    = r_overflow;
  assign drop_count  = r_drop_count;
  assign done        = r_done;
  assign pass        = r_pass;
  assign exit_code   = r_exit_code;
  assign timeout     = r_timeout;
  assign state       = r_state;

endmodule
